// File: rtl/tetris_pkg.sv
// Shared types and dimensions for the LED board scanner.
package tetris_pkg;

    localparam int unsigned ROWS  = 8;
    localparam int unsigned COLS  = 4;
    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam int unsigned CNT_W = 8;
    localparam int unsigned IMG_W = ROWS * COLS;

    // Board image: element r is row r, bit c within it is column c.
    typedef logic [ROWS-1:0][COLS-1:0] board_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_BLANK = 2'd2,
        ST_DRIVE = 2'd3
    } scan_state_e;

endpackage

// File: rtl/row_dec.sv
// 3-to-8 one-hot row decoder with an all-off enable.
module row_dec
    import tetris_pkg::*;
(
    input  logic [ROW_W-1:0] row_idx,
    input  logic             en,
    output logic [ROWS-1:0]  row_onehot_c
);

    // Exactly one bit when enabled, none otherwise.
    always_comb begin
        row_onehot_c = '0;
        if (en) begin
            row_onehot_c[row_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/board_scan.sv
// Row-multiplexed LED board scanner: latches a board image at frame start and
// drives it row by row with a blanking gap before each row.
module board_scan
    import tetris_pkg::*;
#(
    parameter int unsigned DWELL = 16,
    parameter int unsigned BLANK = 2
) (
    input  logic             clka,
    input  logic             restart,
    input  logic             enable,
    input  logic [IMG_W-1:0] board_in,
    input  logic             board_valid,
    output logic             board_ack,
    output logic [ROWS-1:0]  row_sel,
    output logic [COLS-1:0]  col_out,
    output logic [ROW_W-1:0] scan_row,
    output logic             frame_done
);

    // Counters hold "cycles remaining minus one" so a state lasts load+1 cycles.
    localparam logic [CNT_W-1:0] DWELL_LD  = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LD  = CNT_W'(BLANK - 1);
    localparam logic             HAS_BLANK = (BLANK != 0);

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ROW_W-1:0] row_q, row_d;
    board_t           shadow_q, shadow_d;
    logic             ack_d, done_d, drive_d;
    logic [COLS-1:0]  col_d;
    logic [ROWS-1:0]  row_sel_d;

    // Next-state, counter, shadow and next-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        row_d    = row_q;
        shadow_d = shadow_q;
        ack_d    = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (board_valid) begin
                    shadow_d = board_t'(board_in);
                    ack_d    = 1'b1;
                end
                row_d = '0;
                if (HAS_BLANK) begin
                    state_d = ST_BLANK;
                    cnt_d   = BLANK_LD;
                end else begin
                    state_d = ST_DRIVE;
                    cnt_d   = DWELL_LD;
                end
            end
            ST_BLANK: begin
                if (cnt_q == '0) begin
                    state_d = ST_DRIVE;
                    cnt_d   = DWELL_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (row_q == ROW_W'(ROWS - 1)) begin
                    // Frame boundary: the only place enable is honoured.
                    done_d  = 1'b1;
                    row_d   = '0;
                    cnt_d   = '0;
                    state_d = enable ? ST_LOAD : ST_IDLE;
                end else begin
                    row_d = row_q + ROW_W'(1);
                    if (HAS_BLANK) begin
                        state_d = ST_BLANK;
                        cnt_d   = BLANK_LD;
                    end else begin
                        state_d = ST_DRIVE;
                        cnt_d   = DWELL_LD;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs follow the next state so they register in step with it.
        drive_d = (state_d == ST_DRIVE);
        col_d   = drive_d ? shadow_d[row_d] : '0;
    end

    row_dec u_row_dec (
        .row_idx      (row_d),
        .en           (drive_d),
        .row_onehot_c (row_sel_d)
    );

    // State, counter, shadow buffer and registered outputs.
    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            row_q      <= '0;
            shadow_q   <= '0;
            board_ack  <= 1'b0;
            frame_done <= 1'b0;
            row_sel    <= '0;
            col_out    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            shadow_q   <= shadow_d;
            board_ack  <= ack_d;
            frame_done <= done_d;
            row_sel    <= row_sel_d;
            col_out    <= col_d;
        end
    end

    assign scan_row = row_q;

endmodule

// File: tb/tb_board_scan.sv
// Directed bench for board_scan: default timing instance plus a BLANK=0/DWELL=1 instance.
module tb_board_scan;
    import tetris_pkg::*;

    localparam int B     = 2;
    localparam int D     = 16;
    localparam int SEG   = B + D;
    localparam int FRAME = 1 + 8 * SEG;

    logic clka = 1'b0;
    always #5 clka = ~clka;

    logic        restart, enable, board_valid;
    logic [31:0] board_in;
    logic        board_ack, frame_done;
    logic [7:0]  row_sel;
    logic [3:0]  col_out;
    logic [2:0]  scan_row;

    logic        enable2, board_valid2;
    logic [31:0] board_in2;
    logic        board_ack2, frame_done2;
    logic [7:0]  row_sel2;
    logic [3:0]  col_out2;
    logic [2:0]  scan_row2;

    int total = 0;
    int bad   = 0;

    board_scan dut (
        .clka        (clka),
        .restart     (restart),
        .enable      (enable),
        .board_in    (board_in),
        .board_valid (board_valid),
        .board_ack   (board_ack),
        .row_sel     (row_sel),
        .col_out     (col_out),
        .scan_row    (scan_row),
        .frame_done  (frame_done)
    );

    board_scan #(.DWELL(1), .BLANK(0)) dut2 (
        .clka        (clka),
        .restart     (restart),
        .enable      (enable2),
        .board_in    (board_in2),
        .board_valid (board_valid2),
        .board_ack   (board_ack2),
        .row_sel     (row_sel2),
        .col_out     (col_out2),
        .scan_row    (scan_row2),
        .frame_done  (frame_done2)
    );

    typedef struct packed {
        logic [31:0]     img_in;
        logic            valid;
        logic [7:0][3:0] exp_col;   // expected nibble per row, row 7 first
    } vec_t;

    vec_t vecs [5];

    task automatic step();
        @(posedge clka);
        @(negedge clka);
    endtask

    task automatic chk(input string name, input int o,
                       input logic [7:0] rs, input logic [3:0] col, input logic [2:0] row,
                       input logic ack, input logic done,
                       input logic [7:0] e_rs, input logic [3:0] e_col, input logic [2:0] e_row,
                       input logic e_ack, input logic e_done);
        total++;
        if (rs !== e_rs || col !== e_col || row !== e_row || ack !== e_ack || done !== e_done) begin
            bad++;
            $display("FAIL %s o=%0d got rs=%h col=%h row=%0d ack=%b done=%b want rs=%h col=%h row=%0d ack=%b done=%b",
                     name, o, rs, col, row, ack, done, e_rs, e_col, e_row, e_ack, e_done);
        end
    endtask

    // Checks one frame cycle by cycle, starting just after the LOAD cycle sample.
    // kind: 0 none, 1 present next image at act_o, 2 drop enable at act_o, 3 restart at act_o.
    task automatic run_frame(input string name, input logic [7:0][3:0] img, input logic e_ack,
                             input int act_o, input int kind,
                             input logic [31:0] nxt_in, input logic nxt_valid);
        for (int o = 1; o < FRAME; o++) begin
            int         r, p;
            logic [7:0] ers;
            logic [3:0] ecol;
            step();
            r    = (o - 1) / SEG;
            p    = (o - 1) % SEG;
            ers  = (p >= B) ? 8'(1 << r) : 8'h00;
            ecol = (p >= B) ? img[3'(r)] : 4'h0;
            chk(name, o, row_sel, col_out, scan_row, board_ack, frame_done,
                ers, ecol, 3'(r), (o == 1) && e_ack, 1'b0);
            if (o == 1) begin
                board_valid = 1'b0;
                board_in    = 32'hDEAD_BEEF;
            end
            if (o == act_o) begin
                if (kind == 1) begin
                    board_in    = nxt_in;
                    board_valid = nxt_valid;
                end else if (kind == 2) begin
                    enable = 1'b0;
                end else if (kind == 3) begin
                    restart = 1'b1;
                    #1;
                    chk({name, "_async"}, o, row_sel, col_out, scan_row, board_ack, frame_done,
                        8'h00, 4'h0, 3'd0, 1'b0, 1'b0);
                    return;
                end
            end
        end
        step();
        chk({name, "_end"}, FRAME, row_sel, col_out, scan_row, board_ack, frame_done,
            8'h00, 4'h0, 3'd0, 1'b0, 1'b1);
    endtask

    initial begin
        vecs[0] = '{img_in: 32'h0000_000F, valid: 1'b1,
                    exp_col: {4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF}};
        vecs[1] = '{img_in: 32'hA500_0000, valid: 1'b1,
                    exp_col: {4'hA, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0}};
        vecs[2] = '{img_in: 32'h1234_5678, valid: 1'b1,
                    exp_col: {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8}};
        vecs[3] = '{img_in: 32'hFFFF_FFFF, valid: 1'b0,
                    exp_col: {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8}};
        vecs[4] = '{img_in: 32'h8421_C3E7, valid: 1'b1,
                    exp_col: {4'h8, 4'h4, 4'h2, 4'h1, 4'hC, 4'h3, 4'hE, 4'h7}};

        restart      = 1'b1;
        enable       = 1'b0;
        board_valid  = 1'b0;
        board_in     = 32'h0;
        enable2      = 1'b0;
        board_valid2 = 1'b0;
        board_in2    = 32'h0;

        repeat (3) step();
        chk("reset", 0, row_sel, col_out, scan_row, board_ack, frame_done,
            8'h00, 4'h0, 3'd0, 1'b0, 1'b0);

        restart = 1'b0;
        repeat (3) step();
        chk("idle_hold", 0, row_sel, col_out, scan_row, board_ack, frame_done,
            8'h00, 4'h0, 3'd0, 1'b0, 1'b0);

        // First frame: LOAD the cycle after enable is sampled, ack the cycle after.
        board_in    = vecs[0].img_in;
        board_valid = vecs[0].valid;
        enable      = 1'b1;
        step();
        chk("load0", 0, row_sel, col_out, scan_row, board_ack, frame_done,
            8'h00, 4'h0, 3'd0, 1'b0, 1'b0);

        // Each frame shows vecs[i]; the next image is offered mid-frame at row 3.
        // The last frame drops enable during row 2 instead.
        for (int i = 0; i < 5; i++) begin
            int nx;
            nx = (i < 4) ? i + 1 : i;
            run_frame($sformatf("frame%0d", i), vecs[i].exp_col, vecs[i].valid,
                      (i < 4) ? 1 + 3 * SEG + B : 1 + 2 * SEG + B,
                      (i < 4) ? 1 : 2,
                      vecs[nx].img_in, vecs[nx].valid);
        end

        for (int k = 0; k < 5; k++) begin
            step();
            chk("idle_after", k, row_sel, col_out, scan_row, board_ack, frame_done,
                8'h00, 4'h0, 3'd0, 1'b0, 1'b0);
        end

        // Restart during row 5 dwell: frame discarded, shadow cleared.
        enable = 1'b1;
        step();
        chk("load_abort", 0, row_sel, col_out, scan_row, board_ack, frame_done,
            8'h00, 4'h0, 3'd0, 1'b0, 1'b0);
        run_frame("abort", vecs[4].exp_col, 1'b0, 1 + 5 * SEG + B + 3, 3, 32'h0, 1'b0);
        @(negedge clka);
        chk("in_restart", 0, row_sel, col_out, scan_row, board_ack, frame_done,
            8'h00, 4'h0, 3'd0, 1'b0, 1'b0);
        restart = 1'b0;
        step();
        chk("reload", 0, row_sel, col_out, scan_row, board_ack, frame_done,
            8'h00, 4'h0, 3'd0, 1'b0, 1'b0);
        run_frame("cleared", 32'h0, 1'b0, 0, 0, 32'h0, 1'b0);
        enable = 1'b0;

        // BLANK=0, DWELL=1: 9-cycle frames, a row lit every non-LOAD cycle.
        board_in2    = 32'h1234_5678;
        board_valid2 = 1'b1;
        enable2      = 1'b1;
        step();
        chk("fast_load", 0, row_sel2, col_out2, scan_row2, board_ack2, frame_done2,
            8'h00, 4'h0, 3'd0, 1'b0, 1'b0);
        for (int o = 1; o <= 18; o++) begin
            int         k;
            logic [7:0] ers;
            logic [3:0] ecol;
            logic [2:0] erow;
            step();
            k = o % 9;
            if (k == 0) begin
                ers  = 8'h00;
                ecol = 4'h0;
                erow = 3'd0;
            end else begin
                ers  = 8'(1 << (k - 1));
                ecol = vecs[2].exp_col[3'(k - 1)];
                erow = 3'(k - 1);
            end
            chk("fast", o, row_sel2, col_out2, scan_row2, board_ack2, frame_done2,
                ers, ecol, erow, o == 1, k == 0);
            if (o == 1) begin
                board_valid2 = 1'b0;
                board_in2    = 32'h0;
            end
        end
        enable2 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/board_scan.md
BOARD_SCAN -- requirements
Module: board_scan

Interface
REQ-001 DWELL, default 16, number of clka cycles each row is driven (1..256).
REQ-002 BLANK, default 2, number of all-off clka cycles before each row (0..255).
REQ-003 clka  input  1  single system clock; all state changes on rising edge.
REQ-004 restart  input  1  reset, asynchronous, active-high.
REQ-005 enable  input  1  scan enable, sampled at frame boundaries only.
REQ-006 board_in  input  32  board image from datapath; row r = board_in[4r+3:4r], column c = bit 4r+c.
REQ-007 board_valid  input  1  new board image available; producer holds board_in stable until board_ack.
REQ-008 board_ack  output  1  one-cycle pulse: board_in captured into shadow buffer.
REQ-009 row_sel  output  8  one-hot active-high row drive; all zero when no row is lit.
REQ-010 col_out  output  4  column data for the currently driven row.
REQ-011 scan_row  output  3  index of current row.
REQ-012 frame_done  output  1  one-cycle pulse at end of row 7 dwell.

Function
REQ-013 The block SHALL implement states IDLE, LOAD, BLANK, DRIVE; all outputs SHALL be registered.
REQ-014 IDLE: row_sel=0, col_out=0; enable=1 -> LOAD next cycle, else stay.
REQ-015 LOAD (exactly 1 cycle): if board_valid=1, shadow<=board_in and board_ack=1 in the following cycle only; scan_row<=0; -> BLANK (or DRIVE if BLANK=0).
REQ-016 LOAD with board_valid=0: shadow unchanged, no board_ack, previous image redisplayed.
REQ-017 BLANK: row_sel=0, col_out=0 for exactly BLANK cycles, then -> DRIVE.
REQ-018 DRIVE: row_sel=1<<scan_row, col_out=shadow[4*scan_row+3 : 4*scan_row] for exactly DWELL cycles.
REQ-019 End of DRIVE with scan_row<7: scan_row increments, -> BLANK (or DRIVE if BLANK=0).
REQ-020 End of DRIVE with scan_row=7: frame_done=1 for the next cycle; enable=1 -> LOAD, enable=0 -> IDLE; scan_row wraps to 0.
REQ-021 Continuous frame period SHALL be 1+8*(BLANK+DWELL) cycles (145 with defaults).
REQ-022 enable deasserted mid-frame SHALL NOT truncate the frame; the current frame completes.
REQ-023 board_valid asserted mid-frame SHALL NOT alter shadow until the next LOAD (no tearing); request remains pending.
REQ-024 board_ack and frame_done SHALL never be asserted for more than one consecutive cycle.
REQ-025 row_sel SHALL never have more than one bit set; BLANK to DRIVE transition SHALL never show the previous row.
REQ-026 The dwell/blank counter SHALL be 8 bits, reload on each state entry, no wrap within a state.

Reset
REQ-027 restart=1 SHALL immediately force IDLE, shadow=0, scan_row=0, counter=0, row_sel=0, col_out=0, board_ack=0, frame_done=0.
REQ-028 restart mid-frame SHALL discard the frame; no frame_done or board_ack is produced for it.
REQ-029 After restart release, the first LOAD occurs the cycle after enable=1 is sampled in IDLE.

Structure
REQ-030 The state encoding, ROWS=8 and COLS=4 SHALL live in shared package tetris_pkg.
REQ-031 The 3-to-8 one-hot decode SHALL be the sub-module row_dec; the remainder is one FSM plus counter.

Verification
REQ-032 Reset then enable=1, board_valid=1, board_in=32'h0000_000F -> board_ack pulse at cycle 2; row 0 driven cycles 4-19 with col_out=4'hF; rows 1-7 col_out=0.
REQ-033 Continuous enable, defaults -> frame_done pulses exactly 145 cycles apart; row_sel sequence 01,02,...,80 separated by 2 all-zero cycles.
REQ-034 board_valid=1, board_in=32'hA500_0000 raised at row 3 -> no change until next LOAD; then row 7 col_out=4'hA, row 6 col_out=4'h5; one board_ack.
REQ-035 enable dropped during row 2 -> rows 3-7 still driven, frame_done pulses, then IDLE with row_sel=0.
REQ-036 restart pulsed during row 5 DRIVE -> row_sel=0 same cycle (async); no frame_done; shadow reads 0 on next frame with board_valid=0.
REQ-037 BLANK=0, DWELL=1 -> frame period 9 cycles, row_sel one-hot every cycle, no zero gaps within the frame.
